// File: rtl/int_ctrl_pkg.sv
// rtl/int_ctrl_pkg.sv - shared state encoding and default vectors for int_ctrl
package int_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_IDLE = 2'd1,
    ST_SERV = 2'd2
  } int_state_t;

  localparam logic [31:0] DEF_RESET_VEC  = 32'h0000_0028;
  localparam logic [31:0] DEF_VEC_BASE   = 32'h0000_0100;
  localparam logic [31:0] DEF_VEC_STRIDE = 32'h0000_0010;

endpackage

// File: rtl/int_prio_enc.sv
// rtl/int_prio_enc.sv - combinational lowest-index-wins priority encoder
module int_prio_enc #(
  parameter int NSRC = 4,
  parameter int IDW  = 2
) (
  input  logic [NSRC-1:0] req,
  output logic            any,
  output logic [IDW-1:0]  idx
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    any = 1'b0;
    idx = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (req[i]) begin
        any = 1'b1;
        idx = IDW'(i);
      end
    end
  end

endmodule

// File: rtl/int_ctrl.sv
// rtl/int_ctrl.sv - boot entry plus fixed-priority, non-nesting interrupt source for yPC
module int_ctrl
  import int_ctrl_pkg::*;
#(
  parameter int          NSRC       = 4,
  parameter int          IDW        = 2,
  parameter logic [31:0] RESET_VEC  = DEF_RESET_VEC,
  parameter logic [31:0] VEC_BASE   = DEF_VEC_BASE,
  parameter logic [31:0] VEC_STRIDE = DEF_VEC_STRIDE
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NSRC-1:0] irq,
  input  logic            en_we,
  input  logic [NSRC-1:0] en_wdata,
  input  logic            eoi,
  output logic            INT,
  output logic [31:0]     entryPoint,
  output logic            busy,
  output logic [IDW-1:0]  active_id,
  output logic [NSRC-1:0] pending
);

  int_state_t      state_q, state_d;
  logic [NSRC-1:0] irq_q;
  logic [NSRC-1:0] enable_q;
  logic [NSRC-1:0] rise;
  logic [NSRC-1:0] clr;
  logic [NSRC-1:0] pend_d;
  logic            int_d;
  logic [31:0]     ep_d;
  logic            busy_d;
  logic [IDW-1:0]  aid_d;
  logic            req_any;
  logic [IDW-1:0]  req_idx;
  logic [31:0]     req_vec;

  assign rise    = irq & ~irq_q;
  assign req_vec = VEC_BASE + VEC_STRIDE * 32'(req_idx);

  // Dispatch looks at the enable mask as it stood before this edge's write.
  int_prio_enc #(
    .NSRC (NSRC),
    .IDW  (IDW)
  ) u_prio (
    .req (pending & enable_q),
    .any (req_any),
    .idx (req_idx)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_BOOT;
    end else begin
      state_q <= state_d;
    end
  end

  // The !INT guard keeps a dispatch from landing right after the boot pulse.
  always_comb begin
    state_d = state_q;
    int_d   = 1'b0;
    ep_d    = entryPoint;
    busy_d  = busy;
    aid_d   = active_id;
    clr     = '0;
    case (state_q)
      ST_BOOT: begin
        int_d   = 1'b1;
        ep_d    = RESET_VEC;
        state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (req_any && !INT) begin
          int_d        = 1'b1;
          ep_d         = req_vec;
          clr[req_idx] = 1'b1;
          aid_d        = req_idx;
          busy_d       = 1'b1;
          state_d      = ST_SERV;
        end
      end
      ST_SERV: begin
        if (eoi) begin
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_BOOT;
    endcase
    pend_d = (pending & ~clr) | rise;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      INT        <= 1'b0;
      entryPoint <= '0;
      busy       <= 1'b0;
      active_id  <= '0;
      pending    <= '0;
      enable_q   <= '0;
      irq_q      <= '0;
    end else begin
      INT        <= int_d;
      entryPoint <= ep_d;
      busy       <= busy_d;
      active_id  <= aid_d;
      pending    <= pend_d;
      irq_q      <= irq;
      if (en_we) begin
        enable_q <= en_wdata;
      end
    end
  end

endmodule

// File: tb/tb_int_ctrl.sv
// tb/tb_int_ctrl.sv - self-checking bench for int_ctrl: reference model plus directed vectors
module tb_int_ctrl;

  localparam int NSRC = 4;
  localparam int IDW  = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NSRC-1:0] irq;
  logic            en_we;
  logic [NSRC-1:0] en_wdata;
  logic            eoi;
  logic            INT;
  logic [31:0]     entryPoint;
  logic            busy;
  logic [IDW-1:0]  active_id;
  logic [NSRC-1:0] pending;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  int_ctrl #(
    .NSRC (NSRC),
    .IDW  (IDW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .irq        (irq),
    .en_we      (en_we),
    .en_wdata   (en_wdata),
    .eoi        (eoi),
    .INT        (INT),
    .entryPoint (entryPoint),
    .busy       (busy),
    .active_id  (active_id),
    .pending    (pending)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: boot once, then serve one source at a time, lowest index first.
  bit              m_booted  = 1'b0;
  bit              m_serving = 1'b0;
  bit              m_int     = 1'b0;
  logic [31:0]     m_ep      = '0;
  int              m_id      = 0;
  logic [NSRC-1:0] m_pend    = '0;
  logic [NSRC-1:0] m_en      = '0;
  logic [NSRC-1:0] m_prev    = '0;
  logic [NSRC-1:0] m_rise;
  logic [NSRC-1:0] m_req;
  int              m_win;
  bit              m_prev_int = 1'b0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_booted = 0; m_serving = 0; m_int = 0; m_ep = '0; m_id = 0;
      m_pend = '0; m_en = '0; m_prev = '0;
    end else begin
      m_rise = irq & ~m_prev;
      m_req  = m_pend & m_en;
      m_win  = -1;
      for (int i = 0; i < NSRC; i++) if (m_req[i] && m_win < 0) m_win = i;
      if (!m_booted) begin
        m_booted = 1; m_int = 1; m_ep = 32'h28;
      end else if (m_serving) begin
        m_int = 0;
        if (eoi) m_serving = 0;
      end else if (m_win >= 0 && !m_int) begin
        m_int = 1;
        m_ep = 32'h100 + 32'(m_win) * 32'h10;
        m_id = m_win;
        m_serving = 1;
        m_pend[m_win] = 1'b0;
      end else begin
        m_int = 0;
      end
      m_pend = m_pend | m_rise;
      if (en_we) m_en = en_wdata;
      m_prev = irq;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_int", {31'd0, INT}, {31'd0, m_int});
      check("model_ep", entryPoint, m_ep);
      check("model_busy", {31'd0, busy}, {31'd0, m_serving});
      if (m_serving) check("model_id", 32'(active_id), 32'(m_id));
      check("model_pending", 32'(pending), 32'(m_pend));
      if (m_prev_int) check("int_not_back_to_back", {31'd0, INT}, 32'd0);
      m_prev_int = INT;
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_int(input string name, input logic [31:0] ep, input int id);
    check({name, "_int"}, {31'd0, INT}, 32'd1);
    check({name, "_ep"}, entryPoint, ep);
    check({name, "_busy"}, {31'd0, busy}, 32'd1);
    check({name, "_id"}, 32'(active_id), 32'(id));
  endtask

  initial begin
    rst_n = 1'b0; irq = '0; en_we = 1'b0; en_wdata = '0; eoi = 1'b0;
    tick(3);
    chk_en = 1'b1;
    check("rst_int", {31'd0, INT}, 32'd0);
    check("rst_ep", entryPoint, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_pending", 32'(pending), 32'd0);

    // boot pulse
    rst_n = 1'b1;
    tick();
    check("boot_int", {31'd0, INT}, 32'd1);
    check("boot_ep", entryPoint, 32'h28);
    check("boot_busy", {31'd0, busy}, 32'd0);
    tick();
    check("boot_int_drop", {31'd0, INT}, 32'd0);

    // single source 2
    en_we = 1'b1; en_wdata = 4'b1111;
    tick();
    en_we = 1'b0;
    irq = 4'b0100;
    tick();
    check("t2_pending", 32'(pending), 32'b0100);
    check("t2_noint", {31'd0, INT}, 32'd0);
    tick();
    expect_int("t2", 32'h120, 2);
    check("t2_pending_clr", 32'(pending), 32'd0);
    irq = '0; eoi = 1'b1;
    tick();
    eoi = 1'b0;
    check("t2_eoi_busy", {31'd0, busy}, 32'd0);

    // simultaneous 3 and 1
    irq = 4'b1010;
    tick();
    check("t3_pending", 32'(pending), 32'b1010);
    tick();
    expect_int("t3a", 32'h110, 1);
    check("t3_pending_left", 32'(pending), 32'b1000);
    irq = '0;
    tick();
    check("t3_serv_noint", {31'd0, INT}, 32'd0);
    eoi = 1'b1;
    tick();
    eoi = 1'b0;
    check("t3_eoi_busy", {31'd0, busy}, 32'd0);
    tick();
    expect_int("t3b", 32'h130, 3);
    eoi = 1'b1;
    tick();
    eoi = 1'b0;
    tick();

    // masked source stays pending until enabled
    en_we = 1'b1; en_wdata = 4'b0000;
    tick();
    en_we = 1'b0;
    irq = 4'b0001;
    tick();
    check("t4_pending", 32'(pending), 32'b0001);
    tick(2);
    check("t4_masked_noint", {31'd0, INT}, 32'd0);
    check("t4_masked_pending", 32'(pending), 32'b0001);
    en_we = 1'b1; en_wdata = 4'b0001;
    tick();
    en_we = 1'b0;
    tick();
    expect_int("t4", 32'h100, 0);

    // re-request of the source in service
    irq = '0;
    tick();
    irq = 4'b0001;
    tick();
    check("t5_pending", 32'(pending), 32'b0001);
    check("t5_noint", {31'd0, INT}, 32'd0);
    check("t5_busy", {31'd0, busy}, 32'd1);
    tick();
    check("t5_still_noint", {31'd0, INT}, 32'd0);
    eoi = 1'b1;
    tick();
    eoi = 1'b0;
    check("t5_eoi_busy", {31'd0, busy}, 32'd0);
    tick();
    expect_int("t5", 32'h100, 0);
    eoi = 1'b1;
    tick();
    eoi = 1'b0;
    tick();
    eoi = 1'b1;
    tick();
    eoi = 1'b0;
    check("t5_stray_eoi_int", {31'd0, INT}, 32'd0);
    check("t5_stray_eoi_busy", {31'd0, busy}, 32'd0);

    // reset in the middle of service
    irq = '0;
    tick();
    irq = 4'b0001;
    tick();
    tick();
    check("t6_busy", {31'd0, busy}, 32'd1);
    irq = 4'b1011;
    tick();
    check("t6_pending", 32'(pending), 32'b1010);
    rst_n = 1'b0; irq = '0;
    tick();
    check("t6_rst_int", {31'd0, INT}, 32'd0);
    check("t6_rst_ep", entryPoint, 32'd0);
    check("t6_rst_busy", {31'd0, busy}, 32'd0);
    check("t6_rst_id", 32'(active_id), 32'd0);
    check("t6_rst_pending", 32'(pending), 32'd0);
    rst_n = 1'b1;
    tick();
    check("t6_boot_int", {31'd0, INT}, 32'd1);
    check("t6_boot_ep", entryPoint, 32'h28);
    check("t6_boot_pending", 32'(pending), 32'd0);
    tick();
    check("t6_boot_drop", {31'd0, INT}, 32'd0);
    tick(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
